// File: rtl/adder_pkg.sv
// Shared constants and helpers for the adder_ip family of blocks.
package adder_pkg;

  // Result entry packing relative to DATA_WIDTH: {ovf, cout, sum}
  localparam int RES_COUT_BIT = 0;
  localparam int RES_OVF_BIT  = 1;
  localparam int RES_EXTRA_W  = 2;

  // FIFO occupancy classification, derived from the current level
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  // Ceiling log2, usable in constant expressions (clog2(1) == 0)
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/adder_sat_counter.sv
// Saturating event counter with synchronous clear; a clear coincident with
// an increment leaves the count at one.
module adder_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

  // Clear-then-increment, holding at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? ONE : '0;
    end else if (inc && (cnt != MAX)) begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/adder_result_fifo.sv
// First-word-fall-through result buffer behind adder_ip. adder_ip cannot be
// stalled, so beats arriving while full are dropped and counted.
module adder_result_fifo
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_sum,
  input  logic                        in_cout,
  input  logic                        in_ovf,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_sum,
  output logic                        out_cout,
  output logic                        out_ovf,
  output logic [clog2(DEPTH):0]       level,
  output logic                        full,
  output logic                        empty,
  input  logic                        clr_stats,
  output logic [CNT_WIDTH-1:0]        drop_cnt,
  output logic [CNT_WIDTH-1:0]        ovf_cnt,
  output logic                        sticky_ovf
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_WIDTH + RES_EXTRA_W;

  // Reject unsupported configurations at elaboration
  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $fatal(1, "adder_result_fifo: DEPTH must be a power of two >= 2");
    end
    if (CNT_WIDTH < 2) begin : g_bad_cnt
      $fatal(1, "adder_result_fifo: CNT_WIDTH must be >= 2");
    end
  endgenerate

  logic [EW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic          r_sticky_ovf;

  logic [PW-1:0] w_level;
  occ_e          w_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic          w_ovf_acc;
  logic [EW-1:0] w_head;

  // Pointers carry one extra MSB, so their difference is the occupancy
  // 0..DEPTH without a separate level register.
  assign w_level = r_wr_ptr - r_rd_ptr;

  // Classify occupancy; full/empty fall out of the class
  always_comb begin
    w_occ = OCC_PARTIAL;
    if (w_level == '0)               w_occ = OCC_EMPTY;
    else if (w_level == PW'(DEPTH))  w_occ = OCC_FULL;
  end

  assign w_full    = (w_occ == OCC_FULL);
  assign w_empty   = (w_occ == OCC_EMPTY);
  assign w_pop     = !w_empty && out_ready;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign w_push    = in_valid && (!w_full || w_pop);
  assign w_drop    = in_valid && w_full && !w_pop;
  assign w_ovf_acc = w_push && in_ovf;

  // Storage is never reset; out_* gating hides whatever it holds
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {in_ovf, in_cout, in_sum};
  end

  // Write pointer advances on every accepted beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_wr_ptr <= '0;
    else if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
  end

  // Read pointer advances on every consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_rd_ptr <= '0;
    else if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
  end

  // Sticky overflow: an accepted overflow beat wins over a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_sticky_ovf <= 1'b0;
    else if (w_ovf_acc) r_sticky_ovf <= 1'b1;
    else if (clr_stats) r_sticky_ovf <= 1'b0;
  end

  adder_sat_counter #(.WIDTH(CNT_WIDTH)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (w_drop),
    .cnt   (drop_cnt)
  );

  adder_sat_counter #(.WIDTH(CNT_WIDTH)) u_ovf_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_stats),
    .inc   (w_ovf_acc),
    .cnt   (ovf_cnt)
  );

  assign w_head     = r_mem[r_rd_ptr[AW-1:0]];
  assign out_valid  = !w_empty;
  assign out_sum    = w_empty ? '0 : w_head[DATA_WIDTH-1:0];
  assign out_cout   = !w_empty && w_head[DATA_WIDTH+RES_COUT_BIT];
  assign out_ovf    = !w_empty && w_head[DATA_WIDTH+RES_OVF_BIT];
  assign level      = w_level;
  assign full       = w_full;
  assign empty      = w_empty;
  assign sticky_ovf = r_sticky_ovf;

endmodule

// File: tb/tb_adder_result_fifo.sv
// Randomised and directed check of adder_result_fifo against a queue model.
module tb_adder_result_fifo;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_sum = '0;
  logic          in_cout = 1'b0;
  logic          in_ovf = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_sum;
  logic          out_cout;
  logic          out_ovf;
  logic [3:0]    level;
  logic          full;
  logic          empty;
  logic          clr_stats = 1'b0;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] ovf_cnt;
  logic          sticky_ovf;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  adder_result_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sum(in_sum),
    .in_cout(in_cout), .in_ovf(in_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .out_ovf(out_ovf), .level(level), .full(full), .empty(empty),
    .clr_stats(clr_stats), .drop_cnt(drop_cnt), .ovf_cnt(ovf_cnt),
    .sticky_ovf(sticky_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a queue of {ovf,cout,sum} plus plain integer stats
  logic [DW+1:0] mq[$];
  int m_drop = 0;
  int m_ovf = 0;
  bit m_sticky = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_drop = 0;
      m_ovf = 0;
      m_sticky = 1'b0;
    end else begin
      bit pop, push, drop, oinc;
      pop  = (mq.size() > 0) && out_ready;
      push = in_valid && ((mq.size() < DEPTH) || pop);
      drop = in_valid && !push;
      oinc = push && in_ovf;
      if (pop)  void'(mq.pop_front());
      if (push) mq.push_back({in_ovf, in_cout, in_sum});
      if (clr_stats) begin
        m_drop = drop ? 1 : 0;
        m_ovf  = oinc ? 1 : 0;
      end else begin
        if (drop && m_drop < CMAX) m_drop++;
        if (oinc && m_ovf < CMAX)  m_ovf++;
      end
      if (oinc) m_sticky = 1'b1;
      else if (clr_stats) m_sticky = 1'b0;
    end
  end

  // Compare every settled cycle against the model
  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en) begin
      logic [DW+1:0] h;
      h = (mq.size() > 0) ? mq[0] : '0;
      chk("out_valid", 64'(out_valid), 64'(mq.size() > 0));
      chk("out_sum",   64'(out_sum),   64'(h[DW-1:0]));
      chk("out_cout",  64'(out_cout),  64'(h[DW]));
      chk("out_ovf",   64'(out_ovf),   64'(h[DW+1]));
      chk("level",     64'(level),     64'(mq.size()));
      chk("full",      64'(full),      64'(mq.size() == DEPTH));
      chk("empty",     64'(empty),     64'(mq.size() == 0));
      chk("drop_cnt",  64'(drop_cnt),  64'(m_drop));
      chk("ovf_cnt",   64'(ovf_cnt),   64'(m_ovf));
      chk("sticky",    64'(sticky_ovf), 64'(m_sticky));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit v, input logic [DW-1:0] s, input bit c,
                       input bit o, input bit rdy, input bit clr);
    in_valid = v; in_sum = s; in_cout = c; in_ovf = o;
    out_ready = rdy; clr_stats = clr;
    cyc();
  endtask

  initial begin
    logic [DW-1:0] exp_seq [8];
    int rdy_pct;
    exp_seq = '{32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h99};

    // Reset and idle
    repeat (3) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (5) drive(0, 0, 0, 0, 0, 0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_sum", 64'(out_sum), 64'd0);
    chk("rst_stats", 64'({drop_cnt, ovf_cnt, sticky_ovf}), 64'd0);

    // Three beats held, then drained in order
    drive(1, 32'h5, 0, 0, 0, 0);
    drive(1, 32'hA, 0, 0, 0, 0);
    drive(1, 32'hF, 0, 0, 0, 0);
    chk("lvl3", 64'(level), 64'd3);
    in_valid = 1'b0; out_ready = 1'b1;
    chk("head5", 64'(out_sum), 64'h5);
    cyc();
    chk("headA", 64'(out_sum), 64'hA);
    chk("lvl2", 64'(level), 64'd2);
    cyc();
    chk("headF", 64'(out_sum), 64'hF);
    chk("lvl1", 64'(level), 64'd1);
    cyc();
    chk("lvl0", 64'(level), 64'd0);
    chk("empty0", 64'(empty), 64'd1);

    // Overfill: 10 beats into 8 slots
    for (int i = 1; i <= 10; i++) drive(1, DW'(i), 0, 0, 0, 0);
    chk("full8", 64'({full, level}), 64'h18);
    chk("drop2", 64'(drop_cnt), 64'd2);
    chk("head1", 64'(out_sum), 64'h1);
    // Push and pop together while full
    drive(1, 32'h99, 0, 0, 1, 0);
    chk("fpp_lvl", 64'(level), 64'd8);
    chk("fpp_drop", 64'(drop_cnt), 64'd2);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("drain", 64'(out_sum), 64'(exp_seq[i]));
      cyc();
    end
    chk("drained", 64'(empty), 64'd1);

    // Overflow stats and clear-with-set
    for (int i = 0; i < 4; i++) drive(1, DW'(i + 32'h40), 1, 1, 1, 0);
    chk("ovf4", 64'(ovf_cnt), 64'd4);
    chk("sticky1", 64'(sticky_ovf), 64'd1);
    drive(1, 32'h77, 0, 1, 1, 1);
    chk("clr_ovf", 64'(ovf_cnt), 64'd1);
    chk("clr_sticky", 64'(sticky_ovf), 64'd1);
    chk("clr_drop", 64'(drop_cnt), 64'd0);
    repeat (3) drive(0, 0, 0, 0, 1, 0);
    chk("empty2", 64'(empty), 64'd1);

    // Drop counter saturation
    for (int i = 0; i < 28; i++) drive(1, DW'(i + 32'h100), 0, 0, 0, 0);
    chk("sat_drop", 64'(drop_cnt), 64'd15);

    // Asynchronous reset mid-drain
    repeat (3) drive(0, 0, 0, 0, 1, 0);
    chk("lvl5", 64'(level), 64'd5);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    repeat (2) cyc();
    rst_n = 1'b1;

    // Randomised traffic in phases of differing consumer pressure
    for (int p = 0; p < 16; p++) begin
      rdy_pct = $urandom_range(5, 100);
      for (int i = 0; i < 100; i++) begin
        drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom), 1'($urandom),
              $urandom_range(0, 99) < rdy_pct, $urandom_range(0, 31) == 0);
      end
    end
    drive(0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/adder_result_fifo.md
Name: adder_result_fifo

Overview:
- Downstream stage of adder_ip. Captures each result beat (sum, cout, ovf) when adder_ip asserts valid_out.
- adder_ip has no backpressure, so this block buffers results in a first-word-fall-through FIFO and presents them to the consumer over a valid/ready handshake.
- It also keeps saturating drop and overflow statistics plus a sticky overflow flag for software/bench observation.

Parameters:
- DATA_WIDTH, 32, width of sum; must match the adder_ip instance.
- DEPTH, 8, FIFO entries; power of two, >= 2; elaboration $fatal otherwise.
- CNT_WIDTH, 16, width of drop_cnt and ovf_cnt; >= 2.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  result beat present; connects to adder_ip valid_out.
- in_sum  in  DATA_WIDTH  result sum.
- in_cout  in  1  result carry-out.
- in_ovf  in  1  result overflow.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_sum  out  DATA_WIDTH  head sum.
- out_cout  out  1  head carry-out.
- out_ovf  out  1  head overflow.
- level  out  clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- clr_stats  in  1  synchronous clear of drop_cnt, ovf_cnt and sticky_ovf.
- drop_cnt  out  CNT_WIDTH  beats dropped while full; saturating.
- ovf_cnt  out  CNT_WIDTH  accepted beats with in_ovf=1; saturating.
- sticky_ovf  out  1  set by any accepted beat with in_ovf=1.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - wr_ptr, rd_ptr and level are 0; empty=1, full=0, out_valid=0.
  - out_sum=0, out_cout=0, out_ovf=0.
  - drop_cnt=0, ovf_cnt=0, sticky_ovf=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all entries. Deassertion is synchronised externally; the block does not resynchronise it.
- Pointers: (clog2(DEPTH)+1) bits. The extra MSB distinguishes full from empty. Wrap-around is natural modulo 2*DEPTH. Memory index is the low clog2(DEPTH) bits.
- pop = out_valid && out_ready.
- push = in_valid && (!full || pop): when full, a simultaneous pop frees the slot and the push is accepted.
- Entry packing is {ovf, cout, sum}, DATA_WIDTH+2 bits, written at the write pointer on a push edge.
- Latency and output gating:
  - First-word-fall-through: a beat pushed at edge N appears on out_* with out_valid=1 after edge N.
  - out_valid = !empty.
  - out_* are forced to 0 when empty, so stale data is never visible.
- Ordering is strictly FIFO; an entry is removed only on pop.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on push+pop or on idle.
  - Push+pop while empty is impossible, since pop requires out_valid.
- Occupancy states derive from level: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
  - EMPTY->PARTIAL on push.
  - PARTIAL->FULL on push without pop at level DEPTH-1.
  - FULL->PARTIAL on pop without push.
  - PARTIAL->EMPTY on pop without push at level 1.
- Drop: in_valid && full && !pop increments drop_cnt. The beat is lost and the FIFO is unchanged.
- ovf_cnt increments when push && in_ovf.
- Both counters saturate at all-ones; they never wrap.
- clr_stats:
  - Counters clear. An increment in the same cycle yields 1, not 0.
  - sticky_ovf clears unless push && in_ovf in the same cycle; set wins.
  - FIFO contents are unaffected.
- All outputs are registered-state derived; there is no combinational path from in_* to out_*.
- out_ready to out_valid has no same-cycle dependency beyond pop.

Decomposition:
- adder_pkg additions:
  - Field offset constants for entry packing: RES_OVF_BIT and RES_COUT_BIT, relative to DATA_WIDTH.
  - Reuse of adder_pkg::clog2 for pointer and level widths.
  - No parameterised structs in the package.
- One sub-module, adder_sat_counter:
  - Parameter WIDTH.
  - Inputs clk, rst_n, clr, inc; output cnt.
  - Clear-then-increment, saturating.
  - Instantiated twice, for drop_cnt and ovf_cnt.
- Storage is an inferred register array inside adder_result_fifo.

Test Plan:
- Reset, then idle 5 cycles -> out_valid=0, empty=1, level=0, out_sum=0, drop_cnt=0, ovf_cnt=0, sticky_ovf=0.
- Push sums 0x5, 0xA, 0xF (cout=0, ovf=0) with out_ready=0, then out_ready=1 -> level 3, then out_sum 0x5, 0xA, 0xF on consecutive cycles; level 3->2->1->0; empty=1 after.
- DEPTH=8: push 10 beats (sum=1..10) with out_ready=0 -> full=1, level=8, drop_cnt=2; draining yields 1..8 only.
- While full, assert in_valid=1 (sum=0x99) and out_ready=1 together -> head popped, 0x99 accepted, level stays 8, drop_cnt unchanged; 0x99 emerges last.
- Push 4 beats with ovf=1 -> ovf_cnt=4, sticky_ovf=1; then clr_stats=1 with a concurrent ovf=1 push -> ovf_cnt=1, sticky_ovf=1.
- CNT_WIDTH=4, FIFO full, 20 dropped beats -> drop_cnt=15 (saturated).
- Assert rst_n low mid-drain at level 5 -> out_valid=0 and level=0 immediately, without waiting for a clk edge.
